// File: rtl/mux_nto1_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_nto1_pipe_pkg
// Description : Shared defaults and skid-buffer state encoding for mux_nto1_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
package mux_nto1_pipe_pkg;

    localparam int unsigned c_def_width     = 32;
    localparam int unsigned c_def_num_in    = 4;
    localparam int unsigned c_def_sel_w     = 2;
    localparam logic [31:0] c_def_oor_value = 32'h0000_0000;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_t;

endpackage
`default_nettype wire

// File: rtl/mux_nto1_pipe_skid_buffer_2.sv
`default_nettype none
// ============================================================================
// Module      : skid_buffer_2
// Description : Two-entry valid/ready buffer (main + skid register) with flush.
// Revision    : 1.0 - initial release
// ============================================================================
module skid_buffer_2
    import mux_nto1_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = c_def_width
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    buf_state_t       r_state;
    buf_state_t       w_state_nxt;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             w_accept;
    logic             w_drain;
    logic             w_load_main_in;
    logic             w_load_main_skid;
    logic             w_load_skid;

    assign in_ready  = !Reset && (r_state != FULL);
    assign out_valid = (r_state != EMPTY);
    assign out_data  = r_main;
    assign w_accept  = in_valid && in_ready;
    assign w_drain   = out_valid && out_ready;

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush) begin
            w_state_nxt = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt    = ONE;
                        w_load_main_in = 1'b1;
                    end
                end
                ONE: begin
                    case ({w_accept, w_drain})
                        2'b11: w_load_main_in = 1'b1;
                        2'b10: begin
                            w_state_nxt = FULL;
                            w_load_skid = 1'b1;
                        end
                        2'b01: w_state_nxt = EMPTY;
                        default: w_state_nxt = ONE;
                    endcase
                end
                FULL: begin
                    // in_ready is low here, so only a drain can move the state
                    if (w_drain) begin
                        w_state_nxt      = ONE;
                        w_load_main_skid = 1'b1;
                    end
                end
                default: w_state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_main_in) begin
                r_main <= in_data;
            end else if (w_load_main_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= in_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mux_nto1_pipe.sv
`default_nettype none
// ============================================================================
// Module      : mux_nto1_pipe
// Description : Registered N-to-1 word selector with valid/ready skid buffering,
//               out-of-range select detection and flush.
//               MUXSEL_ERR_CNT_EN adds a saturating sel_err_cnt output.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_nto1_pipe
    import mux_nto1_pipe_pkg::*;
#(
    parameter int unsigned      WIDTH     = c_def_width,
    parameter int unsigned      NUM_IN    = c_def_num_in,
    parameter int unsigned      SEL_W     = c_def_sel_w,
    parameter logic [WIDTH-1:0] OOR_VALUE = WIDTH'(c_def_oor_value)
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    flush,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_err,
    output logic                    sel_err_sticky
`ifdef MUXSEL_ERR_CNT_EN
    ,
    output logic [7:0]              sel_err_cnt
`endif
);

    logic [WIDTH-1:0] w_word;
    logic             w_oor;
    logic             w_accept;
    logic             r_sel_err;
    logic             r_sel_err_sticky;

    always_comb begin
        w_word = OOR_VALUE;
        for (int i = 0; i < int'(NUM_IN); i++) begin
            if (32'(sel) == 32'(i)) begin
                w_word = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_oor    = (32'(sel) >= NUM_IN);
    assign w_accept = in_valid && in_ready;

    skid_buffer_2 #(
        .WIDTH (WIDTH)
    ) u_skid (
        .Clk       (Clk),
        .Reset     (Reset),
        .flush     (flush),
        .in_data   (w_word),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // Error flags follow the accept, not the buffer, so a flushed word still reports
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_sel_err        <= 1'b0;
            r_sel_err_sticky <= 1'b0;
        end else begin
            r_sel_err <= w_accept && w_oor;
            if (w_accept && w_oor) begin
                r_sel_err_sticky <= 1'b1;
            end
        end
    end

    assign sel_err        = r_sel_err;
    assign sel_err_sticky = r_sel_err_sticky;

`ifdef MUXSEL_ERR_CNT_EN
    logic [7:0] r_err_cnt;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_err_cnt <= 8'd0;
        end else if (r_sel_err && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign sel_err_cnt = r_err_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux_nto1_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_nto1_pipe
// Description : Self-checking bench for mux_nto1_pipe (NUM_IN=3, SEL_W=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_nto1_pipe;

    localparam int unsigned c_width = 32;
    localparam int unsigned c_nin   = 3;
    localparam logic [31:0] c_oor   = 32'hDEAD_BEEF;

    logic                     Clk = 1'b0;
    logic                     Reset;
    logic [c_nin*c_width-1:0] in_data;
    logic [1:0]               sel;
    logic                     in_valid;
    logic                     in_ready;
    logic                     flush;
    logic [c_width-1:0]       out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic                     sel_err;
    logic                     sel_err_sticky;
`ifdef MUXSEL_ERR_CNT_EN
    logic [7:0]               sel_err_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    mux_nto1_pipe #(
        .WIDTH     (c_width),
        .NUM_IN    (c_nin),
        .SEL_W     (2),
        .OOR_VALUE (c_oor)
    ) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .in_data        (in_data),
        .sel            (sel),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .flush          (flush),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .sel_err        (sel_err),
        .sel_err_sticky (sel_err_sticky)
`ifdef MUXSEL_ERR_CNT_EN
        ,
        .sel_err_cnt    (sel_err_cnt)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_ch(input logic [31:0] c0, input logic [31:0] c1, input logic [31:0] c2);
        in_data = {c2, c1, c0};
    endtask

    // Reference model: word queue plus expected error flags, evaluated mid-cycle
    logic [31:0] q[$];
    logic        m_err    = 1'b0;
    logic        m_sticky = 1'b0;
    logic        m_rdy;
    logic        m_acc;
    logic        m_oor;
    logic [31:0] m_word;

    always @(negedge Clk) begin
        m_rdy = !Reset && (q.size() < 2);
        chk("in_ready", in_ready, m_rdy);
        chk("out_valid", out_valid, q.size() > 0);
        if (q.size() > 0) chk("out_data", out_data, q[0]);
        chk("sel_err", sel_err, m_err);
        chk("sel_err_sticky", sel_err_sticky, m_sticky);
        if (Reset) begin
            q.delete();
            m_err    = 1'b0;
            m_sticky = 1'b0;
        end else begin
            m_acc  = in_valid && m_rdy;
            m_oor  = (sel >= 2'd3);
            m_word = m_oor ? c_oor : in_data[sel*c_width +: c_width];
            m_err  = m_acc && m_oor;
            if (m_err) m_sticky = 1'b1;
            if (flush) begin
                q.delete();
            end else begin
                if (q.size() > 0 && out_ready) void'(q.pop_front());
                if (m_acc) q.push_back(m_word);
            end
        end
    end

    initial begin
        Reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b0;
        sel       = 2'd0;
        set_ch(32'h11, 32'h22, 32'h33);
        repeat (3) step();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_sel_err", sel_err, 1'b0);
        chk("rst_sticky", sel_err_sticky, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        Reset = 1'b0;
        #1;
        chk("rel_in_ready", in_ready, 1'b1);

        // basic select, one-cycle latency
        sel = 2'd2; in_valid = 1'b1;
        step();
        chk("t1_out_valid", out_valid, 1'b1);
        chk("t1_out_data", out_data, 32'h33);
        chk("t1_in_ready", in_ready, 1'b1);
        in_valid = 1'b0;
        step();
        chk("t1_drained", out_valid, 1'b0);

        // backpressure fills both entries, then drains in order
        out_ready = 1'b0; sel = 2'd0; in_valid = 1'b1;
        set_ch(32'hA, 32'h22, 32'h33);
        step();
        set_ch(32'hB, 32'h22, 32'h33);
        step();
        chk("bp_in_ready_full", in_ready, 1'b0);
        chk("bp_head", out_data, 32'hA);
        in_valid = 1'b0;
        step();
        chk("bp_hold", out_data, 32'hA);
        out_ready = 1'b1;
        step();
        chk("bp_second", out_data, 32'hB);
        chk("bp_in_ready_back", in_ready, 1'b1);
        step();
        chk("bp_empty", out_valid, 1'b0);

        // out-of-range select
        sel = 2'd3; in_valid = 1'b1;
        step();
        chk("oor_data", out_data, c_oor);
        chk("oor_err", sel_err, 1'b1);
        chk("oor_sticky", sel_err_sticky, 1'b1);
        in_valid = 1'b0;
        step();
        chk("oor_err_pulse", sel_err, 1'b0);
        chk("oor_sticky_hold", sel_err_sticky, 1'b1);

        // flush from FULL with in_valid high
        set_ch(32'h101, 32'h202, 32'h303);
        out_ready = 1'b0; sel = 2'd1; in_valid = 1'b1;
        step();
        sel = 2'd2;
        step();
        sel = 2'd3;
        step();
        chk("full_no_err", sel_err, 1'b0);
        chk("full_in_ready", in_ready, 1'b0);
        flush = 1'b1; sel = 2'd0;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_out_valid", out_valid, 1'b0);
        chk("fl_in_ready", in_ready, 1'b1);

        // flush in ONE with an accepted OOR word in the same cycle
        sel = 2'd0; in_valid = 1'b1;
        step();
        sel = 2'd3; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl2_out_valid", out_valid, 1'b0);
        chk("fl2_err", sel_err, 1'b1);
        out_ready = 1'b1;
        repeat (3) step();
        chk("fl2_nothing_out", out_valid, 1'b0);

        // reset while FULL
        out_ready = 1'b0; sel = 2'd2; in_valid = 1'b1;
        step();
        step();
        Reset = 1'b1; in_valid = 1'b0;
        #1;
        chk("rm_in_ready_low", in_ready, 1'b0);
        step();
        chk("rm_out_valid", out_valid, 1'b0);
        chk("rm_out_data", out_data, 32'h0);
        chk("rm_sticky", sel_err_sticky, 1'b0);
        Reset = 1'b0;
        #1;
        chk("rm_in_ready_rel", in_ready, 1'b1);

`ifdef MUXSEL_ERR_CNT_EN
        out_ready = 1'b1; sel = 2'd3; in_valid = 1'b1;
        repeat (260) step();
        in_valid = 1'b0;
        repeat (2) step();
        chk("cnt_sat", sel_err_cnt, 8'hFF);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("cnt_flush", sel_err_cnt, 8'hFF);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        chk("cnt_reset", sel_err_cnt, 8'h00);
`endif

        // randomised traffic checked by the scoreboard
        for (int i = 0; i < 80; i++) begin
            set_ch($urandom, $urandom, $urandom);
            sel       = 2'($urandom_range(0, 3));
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10 && out_valid; i++) step();
        chk("final_drain", out_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
